// File: rtl/robs_control.sv
// Control sequencer for the 8-bit signed Robertson's multiplier datapath.
// Drives the 15-bit datapath control word and reports busy/done.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for start, datapath untouched
//   LOAD     | load y and x, clear counter and a
//   INIT     | r = {a, x} = {0, multiplier}
//   DEC      | decrement iteration counter
//   TEST     | capture last-iteration flag, branch on r[0]
//   ADD_WAIT | registered adder settling (ADD_LAT cycles)
//   ADD_WB   | rh <= alu (add y, or subtract y on the last iteration)
//   SH       | shift register takes r >>> 1
//   SHWB     | r <= shifted value, loop or finish
//   FINAL    | {a, x} <= r, product now readable
//   DONE     | one-cycle done pulse, start here chains the next multiply
module robs_control #(
    parameter int ADD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zr,
    input  logic        zq,
    output logic [14:0] c,
    output logic        busy,
    output logic        done
);

    localparam int WW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(ADD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_DEC,
        S_TEST,
        S_ADD_WAIT,
        S_ADD_WB,
        S_SH,
        S_SHWB,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [14:0]     c_q, c_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    function automatic logic [14:0] decode_c(input state_t s, input logic lst);
        logic [14:0] v;
        v = '0;
        case (s)
            S_LOAD: begin
                v[0] = 1'b1;
                v[1] = 1'b1;
                v[2] = 1'b1;
                v[3] = 1'b1;
            end
            S_INIT: begin
                v[8] = 1'b1;
                v[9] = 1'b1;
            end
            S_DEC: v[13] = 1'b1;
            S_ADD_WAIT: v[10] = ~lst;
            S_ADD_WB: begin
                v[10]  = ~lst;
                v[8]   = 1'b1;
                v[5:4] = 2'd2;
            end
            S_SH: begin
                v[12] = 1'b1;
                v[11] = 1'b1;
            end
            S_SHWB: begin
                v[8]   = 1'b1;
                v[9]   = 1'b1;
                v[5:4] = 2'd1;
                v[6]   = 1'b1;
            end
            S_FINAL: begin
                v[14] = 1'b1;
                v[3]  = 1'b1;
                v[7]  = 1'b1;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_INIT;
            S_INIT:  state_d = S_DEC;
            S_DEC:   state_d = S_TEST;
            S_TEST: begin
                last_d = zq;
                if (zr) begin
                    state_d = S_SH;
                end else begin
                    state_d = S_ADD_WAIT;
                    wait_d  = WAIT_LOAD;
                end
            end
            S_ADD_WAIT: begin
                if (wait_q == '0) state_d = S_ADD_WB;
                else              wait_d  = wait_q - 1'b1;
            end
            S_ADD_WB: state_d = S_SH;
            S_SH:     state_d = S_SHWB;
            S_SHWB:   state_d = last_q ? S_FINAL : S_DEC;
            S_FINAL:  state_d = S_DONE;
            S_DONE:   state_d = start ? S_LOAD : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Outputs are registered, so decode the state being entered.
        c_d    = decode_c(state_d, last_d);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            wait_q  <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_robs_control.sv
// Bench for robs_control: a behavioural datapath answers the control word,
// results are compared with plain signed multiplication and bit-count timing.
module tb_robs_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        zr;
    logic        zq;
    logic [14:0] c;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    robs_control #(.ADD_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .zr    (zr),
        .zq    (zq),
        .c     (c),
        .busy  (busy),
        .done  (done)
    );

    // Datapath model; rh is kept wide so partial sums never wrap.
    logic [7:0] mcand = 8'h00;
    logic [7:0] mplier = 8'h00;
    logic [7:0] y_r = 8'h00, x_r = 8'h00, a_r = 8'h00, rl_r = 8'h00, srl_r = 8'h00;
    logic [2:0] q_r = 3'd0;
    int         rh_r = 0, srh_r = 0, alu_r = 0;

    assign zr = ~rl_r[0];
    assign zq = (q_r == 3'd0);

    always @(posedge clk) begin
        if (c[0]) y_r <= mcand;
        if (c[1]) q_r <= 3'd0;
        else if (c[13]) q_r <= q_r - 3'd1;
        if (c[2]) a_r <= 8'h00;
        else if (c[14]) a_r <= rh_r[7:0];
        if (c[3]) x_r <= c[7] ? rl_r : mplier;
        alu_r <= c[10] ? rh_r + int'($signed(y_r)) : rh_r - int'($signed(y_r));
        if (c[8]) begin
            case (c[5:4])
                2'd0:    rh_r <= int'($signed(a_r));
                2'd1:    rh_r <= srh_r;
                2'd2:    rh_r <= alu_r;
                default: rh_r <= rh_r;
            endcase
        end
        if (c[9]) rl_r <= c[6] ? srl_r : x_r;
        if (c[12] && c[11]) begin
            srh_r <= rh_r >>> 1;
            srl_r <= {rh_r[0], rl_r[7:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; this cycle is cycle 0 of the operation.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          input bit hold, input bit spurious);
        logic [15:0] exp_p;
        int exp_lat, lat, adds, subs;
        bit got, busy_ok;
        exp_p   = 16'(int'($signed(m)) * int'($signed(q)));
        exp_lat = 36 + 2 * $countones(q);
        mcand   = m;
        mplier  = q;
        start   = 1'b1;
        got = 1'b0; busy_ok = 1'b1; lat = 0; adds = 0; subs = 0;
        for (int n = 1; n <= 80 && !got; n++) begin
            @(negedge clk);
            if (n == 1) check("load_c", 32'(c), 32'h0000_000F);
            if (c[5:4] == 2'd2) begin
                adds++;
                if (!c[10]) subs++;
            end
            if (busy !== !done) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
                lat = n;
            end
            start = hold || (spurious && (n == 5 || n == 20));
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("product", 32'({a_r, x_r}), 32'(exp_p));
        check("add_count", 32'(adds), 32'($countones(q)));
        check("sub_count", 32'(subs), 32'(q[7]));
        check("busy_profile", 32'(busy_ok), 32'd1);
        check("done_c", 32'(c), 32'd0);
    endtask

    task automatic idle_check();
        bit quiet;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || c !== 15'd0) quiet = 1'b0;
        end
        check("idle_after", 32'(quiet), 32'd1);
    endtask

    initial begin
        logic [7:0] rm, rq;
        bit no_done;

        #2 reset = 1'b1;
        #1;
        check("rst_c", 32'(c), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'h03, 8'h05, 1'b0, 1'b0);
        idle_check();
        run_op(8'h05, 8'hFD, 1'b0, 1'b0);
        idle_check();
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        idle_check();
        run_op(8'h7F, 8'h00, 1'b0, 1'b0);
        idle_check();

        // start held: second operation begins straight out of DONE
        run_op(8'h03, 8'h05, 1'b1, 1'b0);
        run_op(8'h03, 8'h05, 1'b1, 1'b0);
        start = 1'b0;
        idle_check();

        // reset in cycle 10 of a running operation
        mcand  = 8'h03;
        mplier = 8'h05;
        start  = 1'b1;
        no_done = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done !== 1'b0) no_done = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("midrst_c", 32'(c), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) no_done = 1'b0;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) no_done = 1'b0;
        end
        check("aborted_no_done", 32'(no_done), 32'd1);
        run_op(8'hFE, 8'h03, 1'b0, 1'b0);
        idle_check();

        // start pulses while busy are ignored
        run_op(8'h03, 8'h05, 1'b0, 1'b1);
        idle_check();

        repeat (20) begin
            do rm = 8'($urandom); while (rm == 8'h80);
            rq = 8'($urandom);
            run_op(rm, rq, 1'b0, 1'b0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
